// File: rtl/hwag_coil_pkg.sv
// Shared types for the coil output guard: per-channel state encoding and channel indices.
package hwag_coil_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        OFF_WAIT = 2'd2
    } coil_state_t;

    localparam int COIL14 = 0;
    localparam int COIL23 = 1;

endpackage

// File: rtl/hwag_coil_guard_ch.sv
// One coil channel: registers the charge request, bounds the dwell time,
// enforces a minimum off time after each fire, and keeps sticky fault flags.
module hwag_coil_guard_ch
    import hwag_coil_pkg::*;
#(
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          ena,
    input  logic          req,
    input  logic [TW-1:0] max_dwell,
    input  logic [TW-1:0] min_off,
    input  logic          fault_clr,
    output logic          coil_out,
    output logic          spark,
    output logic          overdwell,
    output logic          early_req
);

    localparam logic [TW-1:0] ONE = {{(TW-1){1'b0}}, 1'b1};

    coil_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_dly_q, req_dly_d;
    logic          spark_q, spark_d;
    logic          overdwell_q, overdwell_d;
    logic          early_q, early_d;
    logic          rise;

    // Timers stick at all-ones so a stalled channel can never wrap back under a limit.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_comb begin
        rise        = req & ~req_dly_q;
        state_d     = state_q;
        timer_d     = timer_q;
        req_dly_d   = req;
        spark_d     = 1'b0;
        overdwell_d = overdwell_q & ~fault_clr;
        early_d     = early_q & ~fault_clr;

        if (!ena) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise && (max_dwell != '0)) begin
                        state_d = CHARGE;
                        timer_d = ONE;
                    end
                end
                CHARGE: begin
                    if (rise) early_d = 1'b1;
                    // A request that drops on the timeout clock is a normal fire.
                    if (!req || (timer_q >= max_dwell)) begin
                        state_d = OFF_WAIT;
                        timer_d = '0;
                        spark_d = 1'b1;
                        if (req) overdwell_d = 1'b1;
                    end else begin
                        timer_d = sat_inc(timer_q);
                    end
                end
                OFF_WAIT: begin
                    if (rise) early_d = 1'b1;
                    if (timer_q >= min_off) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = sat_inc(timer_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            req_dly_q   <= 1'b0;
            spark_q     <= 1'b0;
            overdwell_q <= 1'b0;
            early_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            req_dly_q   <= req_dly_d;
            spark_q     <= spark_d;
            overdwell_q <= overdwell_d;
            early_q     <= early_d;
        end
    end

    assign coil_out  = (state_q == CHARGE);
    assign spark     = spark_q;
    assign overdwell = overdwell_q;
    assign early_req = early_q;

endmodule

// File: rtl/hwag_coil_guard.sv
// Coil output guard: one independent guard channel per coil pin, sharing
// enable, fault clear and the dwell/off limits.
module hwag_coil_guard
    import hwag_coil_pkg::*;
#(
    parameter int NCH = 2,
    parameter int TW  = 24
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           ena,
    input  logic [NCH-1:0] coil_req,
    input  logic [TW-1:0]  max_dwell,
    input  logic [TW-1:0]  min_off,
    input  logic           fault_clr,
    output logic [NCH-1:0] coil_out,
    output logic [NCH-1:0] spark,
    output logic [NCH-1:0] overdwell,
    output logic [NCH-1:0] early_req
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        hwag_coil_guard_ch #(
            .TW(TW)
        ) u_ch (
            .clk       (clk),
            .nrst      (nrst),
            .ena       (ena),
            .req       (coil_req[c]),
            .max_dwell (max_dwell),
            .min_off   (min_off),
            .fault_clr (fault_clr),
            .coil_out  (coil_out[c]),
            .spark     (spark[c]),
            .overdwell (overdwell[c]),
            .early_req (early_req[c])
        );
    end

endmodule
